// File: rtl/booth_pp_gen_24.sv
// booth_pp_gen_24: two-stage radix-4 Booth partial-product generator for a 24x24 unsigned multiply
module booth_pp_gen_24 #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      a,
    input  logic [23:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      partial_product1,
    output logic [25:0]      partial_product2,
    output logic [25:0]      partial_product3,
    output logic [25:0]      partial_product4,
    output logic [25:0]      partial_product5,
    output logic [25:0]      partial_product6,
    output logic [25:0]      partial_product7,
    output logic [25:0]      partial_product8,
    output logic [25:0]      partial_product9,
    output logic [25:0]      partial_product10,
    output logic [25:0]      partial_product11,
    output logic [25:0]      partial_product12,
    output logic [25:0]      partial_product13,
    output logic [TAG_W-1:0] out_tag
);
    logic             s1_valid, s2_valid, s1_ready, s2_ready;
    logic [23:0]      s1_a;
    logic [12:0]      s1_neg, s1_one, s1_two, neg_d, one_d, two_d;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [25:0]      pp_d [13];
    logic [25:0]      pp_q [13];
    logic [26:0]      b_x;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign out_valid = s2_valid;
    assign out_tag = s2_tag;
    assign b_x = {2'b00, b, 1'b0};

    // b_x[2g+2:2g] is the Booth triplet {b[2g+1], b[2g], b[2g-1]}; 111 decodes as zero, not negative
    for (genvar g = 0; g < 13; g++) begin : g_pp
        logic [2:0]  t;
        logic [25:0] mag;
        assign t = b_x[2*g+2 -: 3];
        assign one_d[g] = t[1] ^ t[0];
        assign two_d[g] = (t == 3'b011) || (t == 3'b100);
        assign neg_d[g] = t[2] && !(t[1] && t[0]);
        assign mag = s1_one[g] ? {2'b00, s1_a} : s1_two[g] ? {1'b0, s1_a, 1'b0} : 26'd0;
        assign pp_d[g] = s1_neg[g] ? 26'd0 - mag : mag;
    end

    // Stage 1: capture multiplicand, Booth selects and tag on input transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a <= '0;
            s1_neg <= '0;
            s1_one <= '0;
            s1_two <= '0;
            s1_tag <= '0;
        end else begin
            if (s1_ready) s1_valid <= in_valid;
            if (in_valid && s1_ready) begin
                s1_a <= a;
                s1_neg <= neg_d;
                s1_one <= one_d;
                s1_two <= two_d;
                s1_tag <= in_tag;
            end
        end
    end

    // Stage 2: register the formed partial products; holds while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_tag <= '0;
            for (int i = 0; i < 13; i++) pp_q[i] <= '0;
        end else begin
            if (s2_ready) s2_valid <= s1_valid;
            if (s1_valid && s2_ready) begin
                s2_tag <= s1_tag;
                for (int i = 0; i < 13; i++) pp_q[i] <= pp_d[i];
            end
        end
    end

    assign partial_product1 = pp_q[0];
    assign partial_product2 = pp_q[1];
    assign partial_product3 = pp_q[2];
    assign partial_product4 = pp_q[3];
    assign partial_product5 = pp_q[4];
    assign partial_product6 = pp_q[5];
    assign partial_product7 = pp_q[6];
    assign partial_product8 = pp_q[7];
    assign partial_product9 = pp_q[8];
    assign partial_product10 = pp_q[9];
    assign partial_product11 = pp_q[10];
    assign partial_product12 = pp_q[11];
    assign partial_product13 = pp_q[12];
endmodule
